// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory responder for the core's load/store port. Accepts one
//            request at a time over valid/ready, waits LATENCY cycles, then
//            performs a byte/half/word access with sign/zero extension chosen
//            by funct3 and returns read data or an error over valid/ready.
// Ports    : clk, rst (async, active-high)
//            req_valid/req_ready/req_we/req_addr/req_wdata/req_funct3 : request
//            rsp_valid/rsp_ready/rsp_rdata/rsp_err                    : response
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             lat_we;
  logic [31:0]      lat_addr, lat_wdata;
  logic [2:0]       lat_funct3;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept, enter_resp;
  logic             cur_we;
  logic [31:0]      cur_addr, cur_wdata;
  logic [2:0]       cur_funct3;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             err_range, err_align, err_funct, acc_err;
  logic [31:0]      word, load_data;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [3:0]       be;
  logic [31:0]      wlanes;

  assign accept = req_valid && req_ready;

  // With LATENCY=0 the access happens on the accept edge itself, before the
  // latches are loaded, so the live request fields are used while in IDLE.
  assign cur_we     = (state == S_IDLE) ? req_we     : lat_we;
  assign cur_addr   = (state == S_IDLE) ? req_addr   : lat_addr;
  assign cur_wdata  = (state == S_IDLE) ? req_wdata  : lat_wdata;
  assign cur_funct3 = (state == S_IDLE) ? req_funct3 : lat_funct3;

  assign offset = cur_addr - ADDR_BASE;
  assign idx    = offset[IDX_W+1:2];
  assign lane   = cur_addr[1:0];

  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_nxt  = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    err_range = (cur_addr < ADDR_BASE) || ((offset >> 2) >= 32'(DEPTH_WORDS));
    // funct3[1:0] selects the width for both signed and unsigned loads
    err_align = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    if (cur_we) err_funct = (cur_funct3 > 3'b010);
    else        err_funct = (cur_funct3 == 3'b011) || (cur_funct3[2:1] == 2'b11);
    acc_err = err_range || err_align || err_funct;
  end

  always_comb begin
    word    = mem[idx];
    ld_byte = word[{lane, 3'b000} +: 8];
    ld_half = lane[1] ? word[31:16] : word[15:0];
    case (cur_funct3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick
  // which bytes land in the word.
  always_comb begin
    case (cur_funct3[1:0])
      2'b00: begin
        be     = 4'b0001 << lane;
        wlanes = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{cur_wdata[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wlanes = cur_wdata;
      end
    endcase
  end

  // Storage is not reset; writes only happen on the edge that enters RESP,
  // which cannot occur while rst holds the FSM in IDLE with req_ready low.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b0;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == S_IDLE);
      if (accept) begin
        lat_we     <= req_we;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        lat_funct3 <= req_funct3;
        cnt        <= CNT_LOAD;
      end else if ((state == S_WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || cur_we) ? 32'h0 : load_data;
      end else if ((state == S_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'h0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder. A byte-addressed memory
//            model computes every expected load result and error flag.
//            A LATENCY=2 instance covers the directed and random traffic; a
//            LATENCY=0 instance covers back-to-back throughput.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [2:0]  req_funct3;

  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [2:0]  z_req_funct3;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .ADDR_BASE(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0), .ADDR_BASE(32'h0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_funct3(z_req_funct3),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] ref_mem [int unsigned];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: little-endian byte memory; access size and signedness from funct3.
  function automatic void model(input bit we, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] f3, output logic [31:0] rd, output bit er);
    int size;
    bit sgn, bad;
    size = 1; sgn = 0; bad = 0;
    case (f3)
      3'd0:    begin size = 1; sgn = 1; end
      3'd1:    begin size = 2; sgn = 1; end
      3'd2:    size = 4;
      3'd4:    begin size = 1; bad = we; end
      3'd5:    begin size = 2; bad = we; end
      default: bad = 1;
    endcase
    er = bad || ((longint'(a) % size) != 0) || (longint'(a) >= longint'(DEPTH) * 4);
    rd = 32'h0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) rd[8*i +: 8] = ref_mem[a + 32'(i)];
        if (sgn && size < 4 && rd[8*size-1])
          for (int i = 8*size; i < 32; i++) rd[i] = 1'b1;
      end
    end
  endfunction

  task automatic drive_req(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] f3);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
  endtask

  // Waits at negedges for req_ready, then returns just after the accept edge.
  task automatic wait_accept(input string tag);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_accept"}, 32'(n < 50), 32'd1);
    @(posedge clk); #1;
  endtask

  // Counts edges from the accept edge (inclusive) to the edge raising rsp_valid.
  task automatic wait_rsp(input string tag);
    int n;
    n = 1;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_latency"}, n, LAT + 1);
  endtask

  task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, input string tag);
    logic [31:0] exp_rd;
    bit          exp_er;
    model(we, a, wd, f3, exp_rd, exp_er);
    @(negedge clk);
    drive_req(we, a, wd, f3);
    wait_accept(tag);
    req_valid = 1'b0;
    wait_rsp(tag);
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_er));
    @(negedge clk);
    chk({tag, "_vclr"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic chk_rst_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e1, e2, rd;
    bit          x1, x2, er;
    logic [31:0] exp_rd_q[$];
    bit          exp_er_q[$];
    int          issued, got, cyc, last;

    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0;
    z_req_funct3 = '0; z_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_rst_outputs("reset");
    rst = 1'b0;

    // Store then load a full word
    txn(1, 32'h10, 32'hDEADBEEF, 3'd2, "sw10");
    txn(0, 32'h10, 32'h0, 3'd2, "lw10");

    // Sub-word stores and sign/zero-extended loads
    txn(1, 32'h13, 32'h00000080, 3'd0, "sb13");
    txn(0, 32'h13, 32'h0, 3'd0, "lb13");
    txn(0, 32'h13, 32'h0, 3'd4, "lbu13");
    txn(0, 32'h10, 32'h0, 3'd2, "lw10b");
    txn(1, 32'h10, 32'h00008001, 3'd1, "sh10");
    txn(0, 32'h10, 32'h0, 3'd1, "lh10");

    // Error cases: misaligned, misaligned store not written, out of range, illegal funct3
    txn(0, 32'h11, 32'h0, 3'd1, "lh11");
    txn(1, 32'h12, 32'h1, 3'd2, "sw12");
    txn(0, 32'h10, 32'h0, 3'd2, "lw10c");
    txn(0, DEPTH * 4, 32'h0, 3'd2, "lw_oor");
    txn(0, 32'h10, 32'h0, 3'd3, "ld_f3_3");
    txn(1, 32'h10, 32'h0, 3'd4, "st_f3_4");

    // Backpressure: response held 5 cycles while a second request waits
    model(0, 32'h10, 32'h0, 3'd2, e1, x1);
    model(0, 32'h13, 32'h0, 3'd4, e2, x2);
    rsp_ready = 1'b0;
    @(negedge clk);
    drive_req(0, 32'h10, 32'h0, 3'd2);
    wait_accept("bp1");
    req_addr = 32'h13; req_funct3 = 3'd4;
    wait_rsp("bp1");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", 32'(rsp_valid), 32'd1);
      chk("bp_rdata_hold", rsp_rdata, e1);
      chk("bp_err_hold", 32'(rsp_err), 32'(x1));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_vclr", 32'(rsp_valid), 32'd0);
    chk("bp_ready_back", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp("bp2");
    chk("bp2_rdata", rsp_rdata, e2);
    chk("bp2_err", 32'(rsp_err), 32'(x2));
    @(negedge clk);

    // Reset during WAIT abandons the store
    txn(1, 32'h20, 32'hA5A5A5A5, 3'd2, "sw20");
    @(negedge clk);
    drive_req(1, 32'h20, 32'h12345678, 3'd2);
    wait_accept("rst_sw");
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; #1;
    chk_rst_outputs("rst_mid");
    @(negedge clk);
    chk_rst_outputs("rst_hold");
    rst = 1'b0;
    txn(0, 32'h20, 32'h0, 3'd2, "lw20");

    // Random traffic: prefill a region, then mixed ops incl. illegal/misaligned/out-of-range
    for (int i = 0; i < 32; i++) txn(1, 32'h100 + 32'(4*i), $urandom, 3'd2, "fill");
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? (DEPTH * 4 + $urandom_range(0, 64))
                                      : (32'h100 + $urandom_range(0, 127));
      txn(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), "rnd");
    end

    // LATENCY=0 instance: back-to-back stream, one response every 2 cycles
    issued = 0; got = 0; cyc = 0; last = -1;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (z_rsp_valid) begin
        chk("z_rdata", z_rsp_rdata, exp_rd_q.pop_front());
        chk("z_err", 32'(z_rsp_err), 32'(exp_er_q.pop_front()));
        if (last >= 0) chk("z_spacing", cyc - last, 2);
        last = cyc;
        got++;
      end
      if (z_req_ready && issued < 8) begin
        z_req_valid  = 1'b1;
        z_req_we     = (issued < 4);
        z_req_addr   = 32'h200 + 32'(4 * (issued % 4));
        z_req_wdata  = $urandom;
        z_req_funct3 = 3'd2;
        model(z_req_we, z_req_addr, z_req_wdata, z_req_funct3, rd, er);
        exp_rd_q.push_back(rd);
        exp_er_q.push_back(er);
        issued++;
      end else begin
        z_req_valid = 1'b0;
      end
    end
    chk("z_done", got, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
